hit_event_gen: RTL

HIT_EVENT_GEN -- requirements
Module: hit_event_gen

---
 rtl/hit_event_gen_pkg.sv | 27 ++
 rtl/hit_event_if.sv | 25 ++
 rtl/hit_event_gen_sync2.sv | 26 ++
 rtl/hit_event_gen.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hit_event_gen_pkg.sv
// Shared game definitions: box-code type, FSM state encoding and default timing
// constants used by the hit detector, LFSR and VGA blocks.
package hit_event_gen_pkg;

  typedef logic [2:0] box_t;

  localparam box_t NO_HIT = 3'd0;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_LOCKOUT_CYCLES  = 25000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_LOCKOUT,
    ST_WAIT_RELEASE
  } state_t;

  // One shared counter serves every timed state, so it is sized for the longer interval.
  function automatic int cntWidth(input int unsigned a, input int unsigned b);
    int unsigned larger;
    larger = (a > b) ? a : b;
    return (larger < 2) ? 1 : $clog2(larger);
  endfunction

endpackage

// File: rtl/hit_event_if.sv
// Hit-event bus between the sensor front end (master) and the game logic (slave).
interface hit_event_if #(
  parameter int SCORE_W = 11
) ();
  import hit_event_gen_pkg::*;

  box_t               target_box;
  logic               game_active;
  logic               hit_valid;
  box_t               hit_box;
  logic               hit_correct;
  logic [SCORE_W-1:0] score;
  logic               busy;

  modport master (
    input  target_box, game_active,
    output hit_valid, hit_box, hit_correct, score, busy
  );

  modport slave (
    output target_box, game_active,
    input  hit_valid, hit_box, hit_correct, score, busy
  );

endinterface

// File: rtl/hit_event_gen_sync2.sv
// Two-flop synchronizer for bringing an asynchronous bus into the clock domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hit_event_gen.sv
// Turns the raw Arduino box code into debounced, locked-out hit events and keeps
// the running score.
module hit_event_gen
  import hit_event_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int          SCORE_W         = 11
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [2:0]  GPIO_1,
  hit_event_if.master bus
);

  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES, LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LO_LAST   = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  box_t             w_sens;
  state_t           r_state, w_stateNext;
  box_t             r_cand, w_candNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext, w_cntInc;
  box_t             r_hitBox;
  logic             r_gameActiveD;
  logic [SCORE_W-1:0] r_score;
  logic             w_gaRise;
  logic             w_hitMatch;
  logic             w_report;

  sync2 #(.WIDTH(3)) u_sync (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .i_d   (GPIO_1),
    .o_q   (w_sens)
  );

  assign w_cntInc   = r_cnt + 1'b1;
  assign w_gaRise   = bus.game_active & ~r_gameActiveD;
  assign w_hitMatch = (r_hitBox == bus.target_box);
  assign w_report   = (r_state == ST_REPORT);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cand  <= NO_HIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cand  <= w_candNext;
      r_cnt   <= w_cntNext;
    end
  end

  // The IDLE cycle that sees the code counts as the first stable sample, so
  // DEBOUNCE only needs DEBOUNCE_CYCLES-1 more matching samples.
  always_comb begin
    w_stateNext = r_state;
    w_candNext  = r_cand;
    w_cntNext   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_sens != NO_HIT && bus.game_active) begin
          w_stateNext = ST_DEBOUNCE;
          w_candNext  = w_sens;
          w_cntNext   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!bus.game_active || w_sens != r_cand) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else if (w_cntInc == DB_LAST) begin
          w_stateNext = ST_REPORT;
          w_cntNext   = '0;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      ST_REPORT: begin
        w_stateNext = ST_LOCKOUT;
        w_cntNext   = '0;
      end
      ST_LOCKOUT: begin
        if (r_cnt == LO_LAST) begin
          w_stateNext = ST_WAIT_RELEASE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_sens != NO_HIT) begin
          w_cntNext = '0;
        end else if (r_cnt == DB_LAST) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Loaded on entry to REPORT so the box is already valid during the pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_hitBox <= NO_HIT;
    end else if (w_stateNext == ST_REPORT) begin
      r_hitBox <= r_cand;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_gameActiveD <= 1'b0;
      r_score       <= '0;
    end else begin
      r_gameActiveD <= bus.game_active;
      if (w_gaRise) begin
        r_score <= '0;
      end else if (w_report && bus.game_active) begin
        if (w_hitMatch) begin
          if (r_score != SCORE_MAX) r_score <= r_score + 1'b1;
        end else if (r_score != '0) begin
          r_score <= r_score - 1'b1;
        end
      end
    end
  end

  assign bus.hit_valid   = w_report;
  assign bus.hit_box     = r_hitBox;
  assign bus.hit_correct = w_report & w_hitMatch;
  assign bus.score       = r_score;
  assign bus.busy        = (r_state == ST_LOCKOUT) || (r_state == ST_WAIT_RELEASE);

endmodule
